// File: rtl/ts_mux_arbiter.sv
// ts_mux_arbiter: packet-granular round-robin scheduler for four TS FIFOs.
// Ports:
//   CLK, RST (sync, active-low)
//   OUT_EN      byte-rate strobe
//   CH_EN       channel enable mask
//   PKT_READY   per-FIFO "whole packet available"
//   DATA_IN_0..3 FIFO read data, valid one cycle after RD_EN
//   RD_EN       one-hot read strobe to the granted FIFO
//   DATA_OUT    muxed TS byte
//   D_VALID_OUT byte valid
//   P_SYNC_OUT  first byte of each packet
//   SEL         granted channel, held for the whole packet
//   NULL_ACTIVE null packet in progress
//   SYNC_ERR    granted packet's first byte was not SYNC_BYTE
module ts_mux_arbiter #(
  parameter int unsigned PKT_LEN     = 188,
  parameter bit          NULL_INSERT = 1'b1,
  parameter logic [7:0]  SYNC_BYTE   = 8'h47
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       OUT_EN,
  input  logic [3:0] CH_EN,
  input  logic [3:0] PKT_READY,
  input  logic [7:0] DATA_IN_0,
  input  logic [7:0] DATA_IN_1,
  input  logic [7:0] DATA_IN_2,
  input  logic [7:0] DATA_IN_3,
  output logic [3:0] RD_EN,
  output logic [7:0] DATA_OUT,
  output logic       D_VALID_OUT,
  output logic       P_SYNC_OUT,
  output logic [1:0] SEL,
  output logic       NULL_ACTIVE,
  output logic       SYNC_ERR
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_SEND = 2'd1,
    S_NULL = 2'd2
  } state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  ptr_q;
  logic [1:0]  sel_q;
  logic        null_q;

  // stage 1: what was fetched in the previous cycle
  logic        v1_q;
  logic        sof1_q;
  logic        nul1_q;
  logic [7:0]  nb1_q;
  logic [1:0]  ch1_q;

  // stage 2: output registers
  logic [7:0]  dout_q;
  logic        dv_q;
  logic        ps_q;
  logic        se_q;

  logic [3:0]  req;
  logic        hit;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        adv;
  logic [7:0]  null_byte;
  logic [7:0]  ch_byte;
  logic [7:0]  byte1;

  // rotating search starting just after the last grant
  always_comb begin
    req  = PKT_READY & CH_EN;
    hit  = 1'b0;
    pick = 2'd0;
    idx  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  assign adv = (state_q != S_ARB) && OUT_EN;

  // null packet: PID 0x1FFF header, 0xFF stuffing
  always_comb begin
    null_byte = 8'hFF;
    if (cnt_q == CW'(0))      null_byte = SYNC_BYTE;
    else if (cnt_q == CW'(1)) null_byte = 8'h1F;
    else if (cnt_q == CW'(2)) null_byte = 8'hFF;
    else if (cnt_q == CW'(3)) null_byte = 8'h10;
  end

  always_comb begin
    ch_byte = DATA_IN_0;
    unique case (ch1_q)
      2'd0: ch_byte = DATA_IN_0;
      2'd1: ch_byte = DATA_IN_1;
      2'd2: ch_byte = DATA_IN_2;
      2'd3: ch_byte = DATA_IN_3;
    endcase
  end

  assign byte1 = nul1_q ? nb1_q : ch_byte;

  assign RD_EN = (state_q == S_SEND && OUT_EN)
               ? (4'b0001 << sel_q) : 4'b0000;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_ARB;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      null_q  <= 1'b0;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      nul1_q  <= 1'b0;
      nb1_q   <= 8'h00;
      ch1_q   <= 2'd0;
      dout_q  <= 8'h00;
      dv_q    <= 1'b0;
      ps_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      v1_q   <= adv;
      sof1_q <= adv && (cnt_q == '0);
      nul1_q <= (state_q == S_NULL);
      nb1_q  <= null_byte;
      ch1_q  <= sel_q;

      dv_q <= v1_q;
      ps_q <= v1_q && sof1_q;
      se_q <= v1_q && sof1_q && !nul1_q
              && (ch_byte != SYNC_BYTE);
      if (v1_q) dout_q <= byte1;

      unique case (state_q)
        S_ARB: begin
          if (hit) begin
            sel_q   <= pick;
            ptr_q   <= pick;
            state_q <= S_SEND;
          end else if (NULL_INSERT) begin
            null_q  <= 1'b1;
            state_q <= S_NULL;
          end
        end
        S_SEND, S_NULL: begin
          if (OUT_EN) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              null_q  <= 1'b0;
              state_q <= S_ARB;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_ARB;
      endcase
    end
  end

  assign DATA_OUT    = dout_q;
  assign D_VALID_OUT = dv_q;
  assign P_SYNC_OUT  = ps_q;
  assign SEL         = sel_q;
  assign NULL_ACTIVE = null_q;
  assign SYNC_ERR    = se_q;

endmodule

// File: tb/tb_ts_mux_arbiter.sv
// tb_ts_mux_arbiter: randomized/directed bench for ts_mux_arbiter
// against a packet-level reference model.
module tb_ts_mux_arbiter;

  localparam int PKT_LEN = 188;

  logic       CLK = 1'b0;
  logic       RST;
  logic       OUT_EN;
  logic [3:0] CH_EN;
  logic [3:0] PKT_READY;
  logic [7:0] din [4];
  logic [3:0] RD_EN;
  logic [7:0] DATA_OUT;
  logic       D_VALID_OUT;
  logic       P_SYNC_OUT;
  logic [1:0] SEL;
  logic       NULL_ACTIVE;
  logic       SYNC_ERR;

  logic       rst2;
  logic [3:0] pr2;
  logic [3:0] rd2;
  logic [7:0] do2;
  logic       dv2;
  logic       ps2;
  logic [1:0] sel2;
  logic       na2;
  logic       se2;

  always #5 CLK = ~CLK;

  ts_mux_arbiter #(.PKT_LEN(PKT_LEN), .NULL_INSERT(1'b1)) dut (
    .CLK(CLK), .RST(RST), .OUT_EN(OUT_EN),
    .CH_EN(CH_EN), .PKT_READY(PKT_READY),
    .DATA_IN_0(din[0]), .DATA_IN_1(din[1]),
    .DATA_IN_2(din[2]), .DATA_IN_3(din[3]),
    .RD_EN(RD_EN), .DATA_OUT(DATA_OUT),
    .D_VALID_OUT(D_VALID_OUT), .P_SYNC_OUT(P_SYNC_OUT),
    .SEL(SEL), .NULL_ACTIVE(NULL_ACTIVE), .SYNC_ERR(SYNC_ERR)
  );

  ts_mux_arbiter #(.PKT_LEN(PKT_LEN), .NULL_INSERT(1'b0)) dut_nn (
    .CLK(CLK), .RST(rst2), .OUT_EN(OUT_EN),
    .CH_EN(CH_EN), .PKT_READY(pr2),
    .DATA_IN_0(din[0]), .DATA_IN_1(din[1]),
    .DATA_IN_2(din[2]), .DATA_IN_3(din[3]),
    .RD_EN(rd2), .DATA_OUT(do2),
    .D_VALID_OUT(dv2), .P_SYNC_OUT(ps2),
    .SEL(sel2), .NULL_ACTIVE(na2), .SYNC_ERR(se2)
  );

  int vecs = 0;
  int errs = 0;
  bit chk2 = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // channel stream: packet n/PKT_LEN, every third ch3 packet has a bad sync
  function automatic logic [7:0] chan_byte(int ch, int n);
    if (n % PKT_LEN == 0) begin
      if (ch == 3 && (n / PKT_LEN) % 3 == 2) return 8'h46;
      return 8'h47;
    end
    return 8'((ch * 61 + n * 7 + 1) & 255);
  endfunction

  function automatic logic [7:0] null_pkt_byte(int pos);
    case (pos)
      0: return 8'h47;
      1: return 8'h1F;
      2: return 8'hFF;
      3: return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  // reference model: mode 0 idle/arb, 1 channel packet, 2 null packet
  int   m_mode, m_pos, m_ptr, m_sel;
  bit   m_nul;
  int   m_cnt [4];
  int   f_cnt [4];
  bit   mid_v, mid_s, mid_e;
  logic [7:0] mid_d;
  bit   out_v, out_s, out_e;
  logic [7:0] out_d;

  function automatic logic [3:0] exp_rd();
    if (m_mode == 1 && OUT_EN) return 4'(1 << m_sel);
    return 4'b0000;
  endfunction

  task automatic model_edge();
    logic [7:0] b;
    int c;
    bit found;
    if (!RST) begin
      m_mode = 0; m_pos = 0; m_ptr = 3; m_sel = 0; m_nul = 0;
      mid_v = 0; mid_s = 0; mid_e = 0; mid_d = 0;
      out_v = 0; out_s = 0; out_e = 0; out_d = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      return;
    end
    out_v = mid_v;
    out_s = mid_s;
    out_e = mid_e;
    if (mid_v) out_d = mid_d;
    mid_v = 0; mid_s = 0; mid_e = 0;
    if (m_mode == 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!found && PKT_READY[c] && CH_EN[c]) begin
          found = 1;
          m_sel = c;
          m_ptr = c;
        end
      end
      if (found) begin
        m_mode = 1; m_pos = 0;
      end else begin
        m_mode = 2; m_pos = 0; m_nul = 1;
      end
    end else if (OUT_EN) begin
      if (m_mode == 1) begin
        b = chan_byte(m_sel, m_cnt[m_sel]);
        m_cnt[m_sel]++;
      end else begin
        b = null_pkt_byte(m_pos);
      end
      mid_v = 1;
      mid_d = b;
      mid_s = (m_pos == 0);
      mid_e = (m_mode == 1) && (m_pos == 0) && (b != 8'h47);
      m_pos++;
      if (m_pos == PKT_LEN) begin
        m_mode = 0; m_nul = 0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] rd_now;
    bit rst_at;
    #1;
    chk("sel", 32'(SEL), m_sel);
    chk("null_active", 32'(NULL_ACTIVE), 32'(m_nul));
    chk("rd_en", 32'(RD_EN), 32'(exp_rd()));
    chk("valid", 32'(D_VALID_OUT), 32'(out_v));
    chk("psync", 32'(P_SYNC_OUT), 32'(out_s));
    chk("sync_err", 32'(SYNC_ERR), 32'(out_e));
    if (out_v) chk("data", 32'(DATA_OUT), 32'(out_d));
    if (chk2) begin
      chk("nn_valid", 32'(dv2), 0);
      chk("nn_null", 32'(na2), 0);
      chk("nn_rd", 32'(rd2), 0);
    end
    rd_now = RD_EN;
    rst_at = RST;
    model_edge();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!rst_at) f_cnt[i] = 0;
      else if (rd_now[i]) begin
        din[i] = chan_byte(i, f_cnt[i]);
        f_cnt[i]++;
      end
    end
  endtask

  initial begin
    int t;
    RST = 1'b0; rst2 = 1'b0; pr2 = 4'h0;
    OUT_EN = 1'b0; CH_EN = 4'hF; PKT_READY = 4'h0;
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00; f_cnt[i] = 0;
    end
    model_edge();
    @(posedge CLK);
    #1;
    step();
    step();
    chk("rst_outs", {20'd0, RD_EN, DATA_OUT, D_VALID_OUT, P_SYNC_OUT,
                     SEL, NULL_ACTIVE, SYNC_ERR}, 0);
    RST = 1'b1;

    // all channels ready, full rate
    OUT_EN = 1'b1; CH_EN = 4'hF; PKT_READY = 4'hF;
    repeat (5 * (PKT_LEN + 1) + 3) step();

    // nothing ready: null packets; second instance stays silent
    PKT_READY = 4'h0;
    rst2 = 1'b0;
    step();
    rst2 = 1'b1;
    chk2 = 1'b1;
    repeat (2 * (PKT_LEN + 1) + 10) step();
    chk2 = 1'b0;

    // sparse byte enable
    PKT_READY = 4'hF;
    t = 0;
    repeat (4 * (PKT_LEN + 1) + 20) begin
      OUT_EN = (t % 4 == 0);
      t++;
      step();
    end

    // channel 1 masked; drop ready[2] mid-packet
    OUT_EN = 1'b1; CH_EN = 4'b1101;
    repeat (4 * (PKT_LEN + 1) + 10) begin
      if (m_mode == 1 && m_sel == 2 && m_pos == 50) PKT_READY[2] = 1'b0;
      if (m_mode == 0) PKT_READY = 4'hF;
      step();
    end

    // channel 3 only: its stream contains bad sync bytes
    CH_EN = 4'b1000;
    repeat (4 * (PKT_LEN + 1) + 10) step();

    // reset in the middle of a packet
    CH_EN = 4'hF;
    t = 0;
    while (!(m_mode == 1 && m_pos == 100) && t < 2000) begin
      step();
      t++;
    end
    if (t >= 2000) chk("wait_pos100", m_pos, 100);
    RST = 1'b0;
    step();
    RST = 1'b1;
    chk("rst_mid", {20'd0, RD_EN, DATA_OUT, D_VALID_OUT, P_SYNC_OUT,
                    SEL, NULL_ACTIVE, SYNC_ERR}, 0);
    step();
    chk("first_grant", 32'(RD_EN), 32'h1);
    repeat (2 * (PKT_LEN + 1)) step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      OUT_EN = ($urandom % 4) != 0;
      if (n % 40 == 0) begin
        PKT_READY = 4'($urandom);
        CH_EN = 4'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ts_mux_arbiter.md
Name: ts_mux_arbiter

Overview:
- Packet-granular round-robin scheduler that shares the single muxed TS output between four per-channel packet FIFOs, one per TS input.
- Sits between the per-channel clock-crossing FIFOs and the output serializer, all in the output clock domain.
- Grants one whole 188-byte packet at a time and paces reads with a byte-rate enable.
- Inserts null packets (PID 0x1FFF) when no channel has a complete packet, so the output rate stays constant.

Parameters:
- PKT_LEN, 188, bytes per TS packet; byte counter width is ceil(log2(PKT_LEN)).
- NULL_INSERT, 1, 1 = emit null packets when no channel is ready; 0 = stay idle.
- SYNC_BYTE, 8'h47, expected first byte of every packet.

Ports:
- CLK  in  1  single clock (output domain); all logic on its rising edge.
- RST  in  1  synchronous, active-low reset (0 = reset).
- OUT_EN  in  1  byte-rate strobe; one byte is advanced per cycle with OUT_EN=1.
- CH_EN  in  4  per-channel enable mask; a disabled channel is never granted.
- PKT_READY  in  4  bit i=1: FIFO i holds at least one complete packet.
- DATA_IN_0..DATA_IN_3  in  8 each  FIFO i read data; valid one cycle after RD_EN[i].
- RD_EN  out  4  one-hot read strobe to the granted FIFO.
- DATA_OUT  out  8  muxed TS byte.
- D_VALID_OUT  out  1  DATA_OUT valid; one cycle per byte.
- P_SYNC_OUT  out  1  high with the first byte of each packet.
- SEL  out  2  index of the granted channel; held for the whole packet.
- NULL_ACTIVE  out  1  high while a null packet is being sent.
- SYNC_ERR  out  1  one-cycle pulse: a granted packet's first byte was not SYNC_BYTE.

Behaviour:
- Reset (RST=0 at an edge): state=ARB, byte counter=0, RR pointer=3 (channel 0 has first priority), pipeline cleared. All outputs are 0: RD_EN, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SEL, NULL_ACTIVE, SYNC_ERR. Reset mid-packet aborts the packet with no further bytes.
- States: ARB, SEND, NULL.
- ARB (one cycle, does not need OUT_EN):
  - Search req = PKT_READY & CH_EN starting at (ptr+1) mod 4, wrapping.
  - First hit i: SEL<=i, ptr<=i, go to SEND.
  - No hit and NULL_INSERT=1: go to NULL, NULL_ACTIVE<=1.
  - No hit and NULL_INSERT=0: stay in ARB.
  - PKT_READY and CH_EN are sampled only in ARB. Changes during SEND/NULL take effect at the next ARB.
- SEND:
  - RD_EN = onehot(SEL) & {4{OUT_EN}}, combinational from registered state.
  - Counter increments on each OUT_EN.
  - When the counter is PKT_LEN-1 with OUT_EN=1: counter<=0, go to ARB.
  - Exactly PKT_LEN read strobes per grant. A PKT_READY drop mid-packet is ignored, since the FIFO guarantees a whole packet.
- NULL:
  - Same counting rule as SEND; RD_EN stays 0.
  - Generated bytes: 0x47, 0x1F, 0xFF, 0x10, then 0xFF for the remaining PKT_LEN-4 bytes.
  - NULL_ACTIVE drops on the transition to ARB.
- Datapath latency, fixed at 2 cycles:
  - Cycle k: OUT_EN=1 advances the counter (and pulses RD_EN in SEND).
  - Cycle k+1: DATA_IN_SEL or the generated null byte is registered.
  - Cycle k+2: DATA_OUT and D_VALID_OUT=1 are visible.
  - P_SYNC_OUT is aligned with the byte for counter=0.
  - SYNC_ERR pulses in the same cycle as that byte when a channel packet's byte 0 is not SYNC_BYTE. The byte is still forwarded unchanged.
- D_VALID_OUT is 0 in every cycle without a byte. OUT_EN gaps produce gaps in D_VALID_OUT; packets are never split across grants.
- With OUT_EN tied high, packets are separated by exactly one idle cycle (the ARB cycle).
- Simultaneous requests: strict rotation, e.g. ptr=1 with all ready grants 2, 3, 0, 1.
- A channel with CH_EN=0 and PKT_READY=1 is skipped and never starves the others.

Test Plan:
- Reset, then all PKT_READY=1, CH_EN=4'hF, OUT_EN=1 -> SEL sequence 0,1,2,3,0; exactly 188 RD_EN pulses per grant; P_SYNC_OUT on each first byte; 1 idle cycle between packets.
- PKT_READY=0, NULL_INSERT=1 -> NULL_ACTIVE=1; DATA_OUT 47 1F FF 10 FF... for 188 bytes, repeated. With NULL_INSERT=0 -> D_VALID_OUT stays 0.
- OUT_EN high 1 cycle in 4 during SEND -> RD_EN only on OUT_EN cycles; each D_VALID_OUT exactly 2 cycles after its RD_EN; the packet completes after 188 strobes.
- CH_EN=4'b1101 with all ready -> channel 1 is never granted; order 0,2,3,0. PKT_READY[2] dropped mid-packet -> the packet still completes at 188 bytes.
- FIFO 3 supplies 0x46 as its first byte -> SYNC_ERR is a single pulse aligned with P_SYNC_OUT; the byte is output unchanged.
- RST=0 at byte 100 of a SEND -> next cycle all outputs are 0; after release, the first grant goes to channel 0.
